// File: rtl/vga_box_scheduler.sv
// ----------------------------------------------------------------------------
// vga_box_scheduler
//
// Sequences the three effect-indicator boxes (volume, pitch, distortion) onto
// the single pixel-write port of the VGA adapter. A box is redrawn when it has
// never been drawn since reset, or when its effect on/off level differs from
// the level it was last drawn with. Pending boxes are served round-robin, and
// each granted box is rastered at one pixel per clock.
//
// Ports
//   Clock         in   1   system clock, rising edge
//   Resetn        in   1   synchronous reset, active low
//   VolumeOn      in   1   volume effect enabled (requester 0)
//   PitchOn       in   1   pitch effect enabled (requester 1)
//   DistortionOn  in   1   distortion effect enabled (requester 2)
//   x             out  8   pixel column (registered)
//   y             out  7   pixel row (registered)
//   colour        out  12  pixel colour, RGB444 (registered)
//   writeEn       out  1   pixel write strobe (registered)
//   Busy          out  1   high while a box is being rastered
// ----------------------------------------------------------------------------
module vga_box_scheduler #(
    parameter int          BOX_W      = 17,
    parameter int          BOX_H      = 7,
    parameter int          Y0         = 21,
    parameter int          X0_VOL     = 25,
    parameter int          X0_PITCH   = 72,
    parameter int          X0_DIST    = 119,
    parameter logic [11:0] ON_COLOUR  = 12'h2C3,
    parameter logic [11:0] OFF_COLOUR = 12'h222
) (
    input  logic        Clock,
    input  logic        Resetn,
    input  logic        VolumeOn,
    input  logic        PitchOn,
    input  logic        DistortionOn,
    output logic [7:0]  x,
    output logic [6:0]  y,
    output logic [11:0] colour,
    output logic        writeEn,
    output logic        Busy
);

    typedef enum logic {
        IDLE = 1'b0,
        DRAW = 1'b1
    } state_t;

    state_t      state_reg, state_next;
    logic [2:0]  shown_reg, shown_next;
    logic [2:0]  valid_reg, valid_next;
    logic [1:0]  rr_reg, rr_next;
    logic [1:0]  box_reg, box_next;
    logic [4:0]  col_reg, col_next;
    logic [2:0]  row_reg, row_next;
    logic [7:0]  x_reg, x_next;
    logic [6:0]  y_reg, y_next;
    logic [11:0] colour_reg, colour_next;
    logic        we_reg, we_next;
    logic        busy_reg, busy_next;

    logic [2:0]  on_lvl;
    logic [2:0]  pend;
    logic        grant_any;
    logic [1:0]  grant_idx;
    logic        last_pixel;

    assign on_lvl = {DistortionOn, PitchOn, VolumeOn};

    // A box needs drawing if it was never drawn or shows a stale level.
    assign pend = ~valid_reg | (on_lvl ^ shown_reg);

    assign last_pixel = (col_reg == 5'(BOX_W - 1)) && (row_reg == 3'(BOX_H - 1));

    function automatic logic [7:0] box_x0(input logic [1:0] idx);
        case (idx)
            2'd0:    box_x0 = 8'(X0_VOL);
            2'd1:    box_x0 = 8'(X0_PITCH);
            default: box_x0 = 8'(X0_DIST);
        endcase
    endfunction

    // Round-robin scan starting at rr_reg; first pending requester wins.
    always_comb begin
        logic [2:0] cand;
        grant_any = 1'b0;
        grant_idx = 2'd0;
        cand      = 3'd0;
        for (int k = 0; k < 3; k++) begin
            cand = {1'b0, rr_reg} + 3'(k);
            if (cand >= 3'd3) begin
                cand = cand - 3'd3;
            end
            if (!grant_any && pend[cand[1:0]]) begin
                grant_any = 1'b1;
                grant_idx = cand[1:0];
            end
        end
    end

    always_comb begin
        state_next  = state_reg;
        shown_next  = shown_reg;
        valid_next  = valid_reg;
        rr_next     = rr_reg;
        box_next    = box_reg;
        col_next    = col_reg;
        row_next    = row_reg;
        x_next      = x_reg;
        y_next      = y_reg;
        colour_next = colour_reg;
        we_next     = 1'b0;
        busy_next   = 1'b0;

        case (state_reg)
            IDLE: begin
                if (grant_any) begin
                    // First pixel is presented on the same edge as the grant.
                    state_next              = DRAW;
                    box_next                = grant_idx;
                    rr_next                 = (grant_idx == 2'd2) ? 2'd0 : grant_idx + 2'd1;
                    shown_next[grant_idx]   = on_lvl[grant_idx];
                    valid_next[grant_idx]   = 1'b1;
                    colour_next             = on_lvl[grant_idx] ? ON_COLOUR : OFF_COLOUR;
                    col_next                = 5'd0;
                    row_next                = 3'd0;
                    x_next                  = box_x0(grant_idx);
                    y_next                  = 7'(Y0);
                    we_next                 = 1'b1;
                    busy_next               = 1'b1;
                end
            end
            DRAW: begin
                if (last_pixel) begin
                    // Forces one idle cycle before the next box can start.
                    state_next = IDLE;
                end else begin
                    if (col_reg == 5'(BOX_W - 1)) begin
                        col_next = 5'd0;
                        row_next = row_reg + 3'd1;
                    end else begin
                        col_next = col_reg + 5'd1;
                    end
                    x_next    = box_x0(box_reg) + 8'(col_next);
                    y_next    = 7'(Y0) + 7'(row_next);
                    we_next   = 1'b1;
                    busy_next = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state_reg  <= IDLE;
            shown_reg  <= 3'd0;
            valid_reg  <= 3'd0;
            rr_reg     <= 2'd0;
            box_reg    <= 2'd0;
            col_reg    <= 5'd0;
            row_reg    <= 3'd0;
            x_reg      <= 8'd0;
            y_reg      <= 7'd0;
            colour_reg <= 12'd0;
            we_reg     <= 1'b0;
            busy_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            shown_reg  <= shown_next;
            valid_reg  <= valid_next;
            rr_reg     <= rr_next;
            box_reg    <= box_next;
            col_reg    <= col_next;
            row_reg    <= row_next;
            x_reg      <= x_next;
            y_reg      <= y_next;
            colour_reg <= colour_next;
            we_reg     <= we_next;
            busy_reg   <= busy_next;
        end
    end

    assign x       = x_reg;
    assign y       = y_reg;
    assign colour  = colour_reg;
    assign writeEn = we_reg;
    assign Busy    = busy_reg;

endmodule

// File: tb/tb_vga_box_scheduler.sv
// ----------------------------------------------------------------------------
// tb_vga_box_scheduler
//
// Directed scenarios followed by random on/off toggling. A reference model,
// evaluated at each rising edge, decides which box is served and pushes that
// box's full pixel list into a queue; a monitor on the falling edge pops one
// entry per observed write and compares, and also checks the write strobe
// and Busy against the model every cycle.
// ----------------------------------------------------------------------------
module tb_vga_box_scheduler;

    logic        Clock;
    logic        Resetn;
    logic        VolumeOn;
    logic        PitchOn;
    logic        DistortionOn;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [11:0] colour;
    logic        writeEn;
    logic        Busy;

    vga_box_scheduler dut (
        .Clock        (Clock),
        .Resetn       (Resetn),
        .VolumeOn     (VolumeOn),
        .PitchOn      (PitchOn),
        .DistortionOn (DistortionOn),
        .x            (x),
        .y            (y),
        .colour       (colour),
        .writeEn      (writeEn),
        .Busy         (Busy)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    typedef struct packed {
        logic [7:0]  px;
        logic [6:0]  py;
        logic [11:0] pc;
    } pix_t;

    pix_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   writes_seen = 0;

    // Reference model state
    bit        exp_we = 1'b0;
    bit        model_started = 1'b0;
    bit        m_draw = 1'b0;
    int        m_left = 0;
    int        m_ptr = 0;
    bit [2:0]  m_shown = 3'b000;
    bit [2:0]  m_valid = 3'b000;
    int        box_x0[3] = '{25, 72, 119};

    // Reference model: a grant pushes the whole box; each box occupies 119
    // write cycles plus one idle cycle before the next grant is possible.
    initial begin
        bit [2:0] on;
        bit       found;
        int       sel;
        int       idx;
        pix_t     p;
        forever begin
            @(posedge Clock);
            on = {DistortionOn, PitchOn, VolumeOn};
            if (!Resetn) begin
                m_draw  = 1'b0;
                m_left  = 0;
                m_ptr   = 0;
                m_shown = 3'b000;
                m_valid = 3'b000;
                exp_q.delete();
                exp_we  = 1'b0;
            end else if (m_draw) begin
                if (m_left == 0) begin
                    m_draw = 1'b0;
                    exp_we = 1'b0;
                end else begin
                    m_left = m_left - 1;
                    exp_we = 1'b1;
                end
            end else begin
                found = 1'b0;
                sel   = 0;
                for (int k = 0; k < 3; k++) begin
                    idx = (m_ptr + k) % 3;
                    if (!found && (!m_valid[idx] || (on[idx] != m_shown[idx]))) begin
                        found = 1'b1;
                        sel   = idx;
                    end
                end
                if (found) begin
                    for (int r = 0; r < 7; r++) begin
                        for (int c = 0; c < 17; c++) begin
                            p.px = 8'(box_x0[sel] + c);
                            p.py = 7'(21 + r);
                            p.pc = on[sel] ? 12'h2C3 : 12'h222;
                            exp_q.push_back(p);
                        end
                    end
                    m_ptr        = (sel + 1) % 3;
                    m_shown[sel] = on[sel];
                    m_valid[sel] = 1'b1;
                    m_draw       = 1'b1;
                    m_left       = 118;
                    exp_we       = 1'b1;
                end else begin
                    exp_we = 1'b0;
                end
            end
            model_started = 1'b1;
        end
    end

    // Monitor / scoreboard
    initial begin
        pix_t e;
        int   hits;
        forever begin
            @(negedge Clock);
            if (model_started) begin
                checks++;
                if (writeEn !== exp_we) begin
                    errors++;
                    $display("FAIL writeEn t=%0t got %b want %b", $time, writeEn, exp_we);
                end
                checks++;
                if (Busy !== exp_we) begin
                    errors++;
                    $display("FAIL busy t=%0t got %b want %b", $time, Busy, exp_we);
                end
                if (writeEn === 1'b1) begin
                    writes_seen++;
                    hits = 0;
                    for (int b = 0; b < 3; b++) begin
                        if (int'(x) >= box_x0[b] && int'(x) <= box_x0[b] + 16 &&
                            int'(y) >= 21 && int'(y) <= 27) begin
                            hits++;
                        end
                    end
                    checks++;
                    if (hits != 1) begin
                        errors++;
                        $display("FAIL in_box t=%0t got (%0d,%0d) in %0d boxes want 1", $time, x, y, hits);
                    end
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL extra_write t=%0t got (%0d,%0d,%h) want no write", $time, x, y, colour);
                    end else begin
                        e = exp_q.pop_front();
                        if (x !== e.px || y !== e.py || colour !== e.pc) begin
                            errors++;
                            $display("FAIL pixel t=%0t got (%0d,%0d,%h) want (%0d,%0d,%h)",
                                     $time, x, y, colour, e.px, e.py, e.pc);
                        end
                    end
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge Clock);
    endtask

    initial begin
        int got_we;
        Resetn       = 1'b0;
        VolumeOn     = 1'b0;
        PitchOn      = 1'b0;
        DistortionOn = 1'b0;
        step(3);

        // Reset state of the registered outputs
        checks++;
        if (x !== 8'd0 || y !== 7'd0 || colour !== 12'd0) begin
            errors++;
            $display("FAIL reset_outputs got (%0d,%0d,%h) want (0,0,000)", x, y, colour);
        end

        // T1: all three boxes drawn in 222 after reset
        Resetn = 1'b1;
        step(380);
        checks++;
        if (writes_seen != 357) begin
            errors++;
            $display("FAIL t1_write_count got %0d want 357", writes_seen);
        end

        // T2: pitch turns on
        PitchOn = 1'b1;
        step(130);
        // volume turns on, leaving the pointer at pitch
        VolumeOn = 1'b1;
        step(130);

        // T3: all levels change together -> pitch, dist, vol
        VolumeOn     = 1'b0;
        PitchOn      = 1'b0;
        DistortionOn = 1'b1;
        step(380);

        // T4: volume level changes mid-draw; distortion pulses during pitch draw
        VolumeOn = 1'b1;
        step(2);
        VolumeOn = 1'b0;
        step(30);
        PitchOn = 1'b1;
        step(40);
        VolumeOn = 1'b1;
        step(120);
        DistortionOn = 1'b0;
        step(3);
        DistortionOn = 1'b1;
        step(400);

        // T5: reset in the middle of a box, then full redraw
        VolumeOn = 1'b0;
        got_we = 0;
        for (int i = 0; i < 300 && got_we == 0; i++) begin
            step(1);
            if (writeEn === 1'b1) got_we = 1;
        end
        checks++;
        if (got_we == 0) begin
            errors++;
            $display("FAIL t5_wait got no write want write within 300 cycles");
        end
        step(50);
        Resetn = 1'b0;
        step(2);
        Resetn = 1'b1;
        step(400);

        // Random toggling of the on levels
        for (int i = 0; i < 4000; i++) begin
            step(1);
            if ($urandom_range(0, 39) == 0) begin
                case ($urandom_range(0, 2))
                    0:       VolumeOn     = ~VolumeOn;
                    1:       PitchOn      = ~PitchOn;
                    default: DistortionOn = ~DistortionOn;
                endcase
            end
        end
        step(400);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending pixels want 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
